// File: rtl/keypad_emulator_pkg.sv
// rtl/keypad_emulator_pkg.sv - keypad column/row constants, ASCII key map and FSM encoding
// Shared with keypad_peripheral so both ends agree on the matrix layout.
package keypad_emulator_pkg;

   localparam logic [3:0] COL1 = 4'b1000;
   localparam logic [3:0] COL2 = 4'b0100;
   localparam logic [3:0] COL3 = 4'b0010;
   localparam logic [3:0] COL4 = 4'b0001;
   localparam logic [3:0] ROW1 = 4'b1000;
   localparam logic [3:0] ROW2 = 4'b0100;
   localparam logic [3:0] ROW3 = 4'b0010;
   localparam logic [3:0] ROW4 = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] col;
      logic [3:0] row;
   } key_pos_t;

   function automatic key_pos_t key_map(input logic [7:0] code);
      key_pos_t p;
      p.valid = 1'b1;
      p.col   = 4'b0000;
      p.row   = 4'b0000;
      case (code)
         8'h31: begin p.col = COL1; p.row = ROW1; end  // '1'
         8'h34: begin p.col = COL1; p.row = ROW2; end  // '4'
         8'h37: begin p.col = COL1; p.row = ROW3; end  // '7'
         8'h2A: begin p.col = COL1; p.row = ROW4; end  // '*'
         8'h32: begin p.col = COL2; p.row = ROW1; end  // '2'
         8'h35: begin p.col = COL2; p.row = ROW2; end  // '5'
         8'h38: begin p.col = COL2; p.row = ROW3; end  // '8'
         8'h30: begin p.col = COL2; p.row = ROW4; end  // '0'
         8'h33: begin p.col = COL3; p.row = ROW1; end  // '3'
         8'h36: begin p.col = COL3; p.row = ROW2; end  // '6'
         8'h39: begin p.col = COL3; p.row = ROW3; end  // '9'
         8'h23: begin p.col = COL3; p.row = ROW4; end  // '#'
         8'h41: begin p.col = COL4; p.row = ROW1; end  // 'A'
         8'h42: begin p.col = COL4; p.row = ROW2; end  // 'B'
         8'h43: begin p.col = COL4; p.row = ROW3; end  // 'C'
         8'h44: begin p.col = COL4; p.row = ROW4; end  // 'D'
         default: p.valid = 1'b0;
      endcase
      return p;
   endfunction

   function automatic logic key_is_valid(input logic [7:0] code);
      key_pos_t p;
      p = key_map(code);
      return p.valid;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - synchronous 8-bit request FIFO with full/empty/count
// Push when full and pop when empty are ignored; pointers wrap on power-of-two depth.
module key_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [7:0]  push_data,
   input  logic        pop,
   output logic [7:0]  pop_data,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 keypad responder: queued key presses driven onto row lines
// Each queued key is held for HOLD_CYCLES, then released for GAP_CYCLES.
module keypad_emulator #(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 64,
   parameter int GAP_CYCLES  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic       key_ready,
   output logic       bad_key,
   output logic       pressing,
   output logic       busy
);
   import keypad_emulator_pkg::*;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   key_pos_t      lat_key;
   logic          pop;
   logic          push;
   logic          accept;
   logic [7:0]    head_code;
   logic          full, empty;
   logic [AW:0]   count;

   assign key_ready = !full;
   assign accept    = key_valid && key_ready;
   assign push      = accept && key_is_valid(key_code);

   key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (key_code),
      .pop       (pop),
      .pop_data  (head_code),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               cnt_nxt   = HOLD_LOAD;
               state_nxt = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (cnt == '0) begin
               cnt_nxt   = GAP_LOAD;
               state_nxt = ST_RELEASE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_RELEASE: begin
            // Chain straight into the next press so back-to-back keys have no idle cycle
            if (cnt == '0) begin
               if (!empty) begin
                  pop       = 1'b1;
                  cnt_nxt   = HOLD_LOAD;
                  state_nxt = ST_PRESS;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         lat_key <= '0;
         bad_key <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bad_key <= accept && !key_is_valid(key_code);
         if (pop) lat_key <= key_map(head_code);
      end
   end

   assign pressing = (state == ST_PRESS);
   assign busy     = (count != '0) || (state != ST_IDLE);
   // The scanner samples rows in the same cycle it strobes cols, so this stays combinational
   assign rows     = (pressing && lat_key.valid && cols == lat_key.col) ? lat_key.row : 4'b0000;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator against a press-schedule model
// The model predicts each key's press start time from accept times; outputs follow from the schedule.
module tb_keypad_emulator;

   localparam int DEPTH = 4;
   localparam int HOLD  = 64;
   localparam int GAP   = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cols;
   logic [3:0] rows;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ready;
   logic       bad_key;
   logic       pressing;
   logic       busy;

   keypad_emulator #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .cols      (cols),
      .rows      (rows),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .bad_key   (bad_key),
      .pressing  (pressing),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      int         start;
   } ent_t;

   ent_t  sched[$];
   int    e;
   int    last_start;
   int    bad_edge;
   int    vectors;
   int    miscompares;
   string keymap[4] = '{"147*", "2580", "369#", "ABCD"};
   string valid_keys = "147*2580369#ABCD";

   function automatic bit pos_of(input logic [7:0] code, output logic [3:0] col, output logic [3:0] row);
      string s;
      col = 4'b0000;
      row = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         s = keymap[c];
         for (int r = 0; r < 4; r++) begin
            if (s[r] == code) begin
               col = 4'b1000 >> c;
               row = 4'b1000 >> r;
               return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [3:0] rand_cols();
      case ($urandom_range(0, 5))
         0: return 4'b1000;
         1: return 4'b0100;
         2: return 4'b0010;
         3: return 4'b0001;
         default: return 4'($urandom);
      endcase
   endfunction

   function automatic logic [7:0] rand_code();
      if ($urandom_range(0, 3) != 0) return valid_keys[$urandom_range(0, 15)];
      return 8'($urandom);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic clear_model();
      sched.delete();
      last_start = -1000;
      bad_edge   = -1;
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs, then advance the model.
   task automatic step(input logic v, input logic [7:0] code, input logic [3:0] c, output bit acc);
      int         cnt;
      int         start;
      bit         prs;
      logic [7:0] pk;
      logic [3:0] pc, pr, er;
      key_valid = v;
      key_code  = code;
      cols      = c;
      #1;
      cnt = 0;
      prs = 1'b0;
      pk  = 8'h00;
      foreach (sched[i]) begin
         if (sched[i].start > e) cnt++;
         if (sched[i].start <= e && e < sched[i].start + HOLD) begin
            prs = 1'b1;
            pk  = sched[i].code;
         end
      end
      er = 4'b0000;
      if (prs) begin
         void'(pos_of(pk, pc, pr));
         if (c == pc) er = pr;
      end
      chk("key_ready", 8'(key_ready), 8'(cnt < DEPTH));
      chk("pressing",  8'(pressing),  8'(prs));
      chk("busy",      8'(busy),      8'(cnt > 0 || (e >= last_start && e < last_start + HOLD + GAP)));
      chk("bad_key",   8'(bad_key),   8'(bad_edge == e));
      chk("rows",      8'(rows),      8'(er));
      acc = v && (cnt < DEPTH);
      @(posedge clk);
      e++;
      if (acc) begin
         if (pos_of(code, pc, pr)) begin
            start = (e + 1 > last_start + HOLD + GAP) ? e + 1 : last_start + HOLD + GAP;
            sched.push_back('{code: code, start: start});
            last_start = start;
         end else begin
            bad_edge = e;
         end
      end
      while (sched.size() > 0 && sched[0].start + HOLD + GAP < e) void'(sched.pop_front());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rand_cols(), acc);
   endtask

   task automatic push_key(input logic [7:0] code);
      bit acc;
      int n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 2000) begin
         step(1'b1, code, rand_cols(), acc);
         n++;
      end
      key_valid = 1'b0;
      chk("push_accepted", 8'(acc), 8'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rows"},      8'(rows),      8'd0);
      chk({tag, "_key_ready"}, 8'(key_ready), 8'd1);
      chk({tag, "_bad_key"},   8'(bad_key),   8'd0);
      chk({tag, "_pressing"},  8'(pressing),  8'd0);
      chk({tag, "_busy"},      8'(busy),      8'd0);
   endtask

   initial begin
      bit acc;
      int n;
      vectors     = 0;
      miscompares = 0;
      e           = 0;
      clear_model();
      reset     = 1'b1;
      key_valid = 1'b0;
      key_code  = 8'h00;
      cols      = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // single key '5'
      push_key(8'h35);
      idle(200);

      // back-to-back '1', '#', 'D'
      push_key(8'h31);
      push_key(8'h23);
      push_key(8'h44);
      idle(450);

      // fill the FIFO while a key is held; fifth push waits for a pop
      push_key(8'h31);
      idle(5);
      push_key(8'h32);
      push_key(8'h33);
      push_key(8'h41);
      push_key(8'h42);
      push_key(8'h43);
      idle(850);

      // invalid key 'Z'
      push_key(8'h5A);
      idle(4);

      // '7' pressed while scanner drives non-matching / non-one-hot columns
      push_key(8'h37);
      idle(3);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, (i % 2 == 0) ? 4'b1100 : 4'b0000, acc);
      idle(200);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 29) == 0, rand_code(), rand_cols(), acc);
      end
      n = 0;
      while (busy && n < 2000) begin
         idle(1);
         n++;
      end
      idle(140);

      // reset in the middle of a press with two keys still queued
      push_key(8'h34);
      push_key(8'h38);
      push_key(8'h43);
      idle(10);
      cols = 4'b1000;
      #1;
      chk("pre_reset_rows", 8'(rows), 8'(4'b0100));
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
